// File: rtl/fft_out_reorder.sv
// Reorders one 16-point FFT frame from bit-reversed to natural bin order through a two-bank ping-pong buffer.
// Latency: bin 0 of a frame is presented the cycle after the frame is captured; 16 beats drain one frame.
// Backpressure: in_ready drops while both banks hold frames; out_ready low stalls the read side with outputs held.
module fft_out_reorder #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_d0,
  input  logic [DATA_W-1:0] in_d1,
  input  logic [DATA_W-1:0] in_d2,
  input  logic [DATA_W-1:0] in_d3,
  input  logic [DATA_W-1:0] in_d4,
  input  logic [DATA_W-1:0] in_d5,
  input  logic [DATA_W-1:0] in_d6,
  input  logic [DATA_W-1:0] in_d7,
  input  logic [DATA_W-1:0] in_d8,
  input  logic [DATA_W-1:0] in_d9,
  input  logic [DATA_W-1:0] in_d10,
  input  logic [DATA_W-1:0] in_d11,
  input  logic [DATA_W-1:0] in_d12,
  input  logic [DATA_W-1:0] in_d13,
  input  logic [DATA_W-1:0] in_d14,
  input  logic [DATA_W-1:0] in_d15,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_idx,
  output logic              out_last
);

  localparam int NPT = 16;

  // Input words gathered into an array; array index is the bit-reversed frequency bin
  logic [DATA_W-1:0] in_w [NPT];

  assign in_w[0]  = in_d0;
  assign in_w[1]  = in_d1;
  assign in_w[2]  = in_d2;
  assign in_w[3]  = in_d3;
  assign in_w[4]  = in_d4;
  assign in_w[5]  = in_d5;
  assign in_w[6]  = in_d6;
  assign in_w[7]  = in_d7;
  assign in_w[8]  = in_d8;
  assign in_w[9]  = in_d9;
  assign in_w[10] = in_d10;
  assign in_w[11] = in_d11;
  assign in_w[12] = in_d12;
  assign in_w[13] = in_d13;
  assign in_w[14] = in_d14;
  assign in_w[15] = in_d15;

  // Ping-pong storage and its bookkeeping; occupancy of both banks is the whole state machine
  logic [DATA_W-1:0] bank_q [2][NPT];
  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [3:0]        cnt_q, cnt_d;

  logic              wr_fire;
  logic              rd_fire;
  logic              rd_done;
  logic [3:0]        rd_addr;

  // Swap the four index bits: natural bin k lives at bit-reversed slot
  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  // A frame is taken only when the bank it would land in is empty
  assign wr_fire = in_valid & ~full_q[wr_bank_q];
  // A beat leaves whenever the read bank holds data and downstream takes it
  assign rd_fire = full_q[rd_bank_q] & out_ready;
  assign rd_done = rd_fire & (cnt_q == 4'd15);

  // Outputs come straight from registers, so a freed bank is only visible the following cycle
  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_idx   = cnt_q;
  assign out_last  = out_valid & (cnt_q == 4'd15);
  assign rd_addr   = bitrev4(cnt_q);
  assign out_data  = out_valid ? bank_q[rd_bank_q][rd_addr] : '0;

  // Next-state for bank occupancy, bank pointers and beat counter
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    cnt_d     = cnt_q;
    // Write and drain can never address the same bank: one needs it empty, the other full
    if (wr_fire) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (rd_fire) begin
      cnt_d = cnt_q + 4'd1;
    end
    if (rd_done) begin
      cnt_d             = 4'd0;
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  // Control registers; reset discards any frame in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      cnt_q     <= 4'd0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      cnt_q     <= cnt_d;
    end
  end

  // Frame capture: all 16 words land in the write bank in one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NPT; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else if (wr_fire) begin
      for (int i = 0; i < NPT; i++) begin
        bank_q[wr_bank_q][i] <= in_w[i];
      end
    end
  end

endmodule
